bkm_slot_host: RTL and testbench

- Monitor-side initiator for the BKM-68X slot bus; the opposite end of the card-side slot interface.
- Converts a simple request/response port into multiplexed address/data cycles with active-low slot-select, strobe, address/data and read/write lines.
- Synchronises and latches the card's interrupt line.
- Used as a bench driver for the card and as the host core of a slot exerciser board.

---
 rtl/bkm_slot_host_pkg.sv | 60 ++++++
 rtl/bkm_slot_host_if.sv | 51 +++++
 rtl/bkm_irq_sync.sv | 37 +++
 rtl/bkm_slot_host.sv | 252 +++++++++++++++++++++++++
 tb/tb_bkm_slot_host.sv | 280 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/bkm_slot_host_pkg.sv
// ---------------------------------------------------------------------------
// bkm_slot_host_pkg
// Shared definitions for the BKM-68X slot bus host:
//   - default phase timing (setup / strobe / hold / turnaround cycles)
//   - default address of the automatic interrupt status read
//   - FSM state encoding (plain localparam constants, 4 bits)
//   - captured request record
//   - phase_load(): counter preload value for a state entry
// Optional feature macro used by the host: BKM_SLOT_HOST_IRQ_AUTOREAD_EN
// ---------------------------------------------------------------------------
package bkm_slot_host_pkg;

   localparam int DEF_SETUP_CYCLES  = 4;
   localparam int DEF_STROBE_CYCLES = 8;
   localparam int DEF_HOLD_CYCLES   = 4;
   localparam int DEF_TURN_CYCLES   = 2;

   localparam logic [7:0] DEF_IRQ_STATUS_ADDR = 8'h00;

   // Phase counter width; every phase length must fit in 1..256 cycles.
   localparam int CNT_W = 8;

   localparam logic [3:0] ST_IDLE     = 4'd0;
   localparam logic [3:0] ST_A_SETUP  = 4'd1;
   localparam logic [3:0] ST_A_STROBE = 4'd2;
   localparam logic [3:0] ST_A_HOLD   = 4'd3;
   localparam logic [3:0] ST_TURN     = 4'd4;
   localparam logic [3:0] ST_D_SETUP  = 4'd5;
   localparam logic [3:0] ST_D_STROBE = 4'd6;
   localparam logic [3:0] ST_D_HOLD   = 4'd7;
   localparam logic [3:0] ST_DONE     = 4'd8;

   typedef struct packed {
      logic       write;
      logic [7:0] addr;
      logic [7:0] wdata;
   } req_t;

   // Value loaded into the phase counter when entering state st.
   // A state lasts (load + 1) cycles; single-cycle states load 0.
   function automatic logic [CNT_W-1:0] phase_load(
      input logic [3:0] st,
      input int         setup_c,
      input int         strobe_c,
      input int         hold_c,
      input int         turn_c
   );
      int n;
      n = 1;
      case (st)
         ST_A_SETUP,  ST_D_SETUP:  n = setup_c;
         ST_A_STROBE, ST_D_STROBE: n = strobe_c;
         ST_A_HOLD,   ST_D_HOLD:   n = hold_c;
         ST_TURN:                  n = turn_c;
         default:                  n = 1;
      endcase
      return CNT_W'(n - 1);
   endfunction

endpackage

// File: rtl/bkm_slot_host_if.sv
// ---------------------------------------------------------------------------
// bkm_slot_host_if
// Bundles the request/response port, the multiplexed slot bus and the
// interrupt lines of the BKM-68X slot host.
//
// Request handshake: a request transfers on a clock edge where req_valid and
// req_ready are both high; req_write/req_addr/req_wdata must be stable while
// req_valid is high. There is no response back-pressure: rsp_valid is a
// one-cycle pulse that the requester must take when it appears.
//
// Modports:
//   master - requester / card side (drives requests, ad_in, irq_x, irq_ack)
//   slave  - the slot host block
// ---------------------------------------------------------------------------
interface bkm_slot_host_if;

   logic       req_valid;
   logic       req_ready;
   logic       req_write;
   logic [7:0] req_addr;
   logic [7:0] req_wdata;

   logic       rsp_valid;
   logic [7:0] rsp_rdata;
   logic       rsp_auto;

   logic       slot_x_int_x;
   logic       clk_rw;
   logic       ax_d;
   logic       r_wx;
   logic [7:0] ad_out;
   logic       ad_oe_x;
   logic [7:0] ad_in;

   logic       irq_x;
   logic       irq_pending;
   logic       irq_ack;

   modport master (
      output req_valid, req_write, req_addr, req_wdata, ad_in, irq_x, irq_ack,
      input  req_ready, rsp_valid, rsp_rdata, rsp_auto,
             slot_x_int_x, clk_rw, ax_d, r_wx, ad_out, ad_oe_x, irq_pending
   );

   modport slave (
      input  req_valid, req_write, req_addr, req_wdata, ad_in, irq_x, irq_ack,
      output req_ready, rsp_valid, rsp_rdata, rsp_auto,
             slot_x_int_x, clk_rw, ax_d, r_wx, ad_out, ad_oe_x, irq_pending
   );

endinterface

// File: rtl/bkm_irq_sync.sv
// ---------------------------------------------------------------------------
// bkm_irq_sync
// Two-flop synchroniser for the card's asynchronous, active-low interrupt
// line, followed by a falling-edge detector.
// Ports:
//   i_clk    in  system clock
//   i_rst_n  in  synchronous active-low reset (all flops reset to 1 = idle)
//   i_irq_x  in  asynchronous interrupt, active low
//   o_fall   out one-cycle pulse on a falling edge of the synchronised line
// ---------------------------------------------------------------------------
module bkm_irq_sync (
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_irq_x,
   output logic o_fall
);

   logic r_sync1;
   logic r_sync2;
   logic r_prev;

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_sync1 <= 1'b1;
         r_sync2 <= 1'b1;
         r_prev  <= 1'b1;
      end else begin
         r_sync1 <= i_irq_x;
         r_sync2 <= r_sync1;
         r_prev  <= r_sync2;
      end
   end

   // Edge is taken only from the fully synchronised value, never from r_sync1.
   assign o_fall = r_prev & ~r_sync2;

endmodule

// File: rtl/bkm_slot_host.sv
// ---------------------------------------------------------------------------
// bkm_slot_host
// Monitor-side initiator for the BKM-68X slot bus. Each request becomes an
// address phase and a data phase (setup / strobe / hold each), with a bus
// turnaround before the data phase of reads. The card interrupt is
// synchronised and latched in irq_pending.
//
// Ports:
//   clk_50mhz_in  in   system clock
//   reset_x       in   synchronous active-low reset
//   io_bus        slave modport of bkm_slot_host_if (request/response port,
//                 slot bus, interrupt lines)
//   o_dbg_state   out  current FSM state (encoding in bkm_slot_host_pkg)
//
// All slot bus and response outputs are registered from the current state,
// so they appear on the pins one cycle after the state is entered. Every
// phase keeps its full length; the response pulse lands 2*(S+T+H)+1 cycles
// after acceptance for writes, plus TURN_CYCLES for reads.
//
// Optional feature macro: BKM_SLOT_HOST_IRQ_AUTOREAD_EN
//   When defined, a pending interrupt seen in IDLE launches a read of
//   IRQ_STATUS_ADDR (in preference to any request); its completion carries
//   rsp_auto=1 and clears irq_pending. When undefined, rsp_auto is 0 and
//   irq_pending is cleared only by irq_ack.
// ---------------------------------------------------------------------------
module bkm_slot_host
   import bkm_slot_host_pkg::*;
#(
   parameter int SETUP_CYCLES  = DEF_SETUP_CYCLES,
   parameter int STROBE_CYCLES = DEF_STROBE_CYCLES,
   parameter int HOLD_CYCLES   = DEF_HOLD_CYCLES,
   parameter int TURN_CYCLES   = DEF_TURN_CYCLES
`ifdef BKM_SLOT_HOST_IRQ_AUTOREAD_EN
   ,
   parameter logic [7:0] IRQ_STATUS_ADDR = DEF_IRQ_STATUS_ADDR
`endif
) (
   input  logic            clk_50mhz_in,
   input  logic            reset_x,
   bkm_slot_host_if.slave  io_bus,
   output logic [3:0]      o_dbg_state
);

   logic [3:0]       r_state;
   logic [3:0]       w_next_state;
   logic [CNT_W-1:0] r_cnt;
   logic             w_cnt_zero;
   req_t             r_req;

   logic             w_accept;
   logic             w_auto_start;
   logic             w_auto_clr;
   logic             w_irq_edge;
   logic             w_in_txn;
   logic             w_a_phase;
   logic             w_d_phase;
   logic             w_strobe;

   logic             r_slot_x;
   logic             r_clk_rw;
   logic             r_ax_d;
   logic             r_r_wx;
   logic [7:0]       r_ad_out;
   logic             r_ad_oe_x;
   logic [7:0]       r_rdata;
   logic             r_rsp_valid;
   logic [7:0]       r_rsp_rdata;
   logic             r_irq_pending;

   // ------------------------------------------------------------------
   // Interrupt synchroniser
   // ------------------------------------------------------------------
   bkm_irq_sync u_irq_sync (
      .i_clk   (clk_50mhz_in),
      .i_rst_n (reset_x),
      .i_irq_x (io_bus.irq_x),
      .o_fall  (w_irq_edge)
   );

   // ------------------------------------------------------------------
   // Request acceptance / automatic status read
   // ------------------------------------------------------------------
`ifdef BKM_SLOT_HOST_IRQ_AUTOREAD_EN
   logic r_auto;
   logic r_rsp_auto;

   assign w_auto_start = (r_state == ST_IDLE) && r_irq_pending;
   assign w_auto_clr   = (r_state == ST_DONE) && r_auto;
`else
   assign w_auto_start = 1'b0;
   assign w_auto_clr   = 1'b0;
`endif

   // The automatic read pre-empts a request, so the port stalls that cycle.
   assign io_bus.req_ready = (r_state == ST_IDLE) && !w_auto_start;
   assign w_accept         = io_bus.req_valid && io_bus.req_ready;

   always_ff @(posedge clk_50mhz_in) begin
      if (!reset_x) begin
         r_req <= '0;
      end else if (w_auto_start) begin
`ifdef BKM_SLOT_HOST_IRQ_AUTOREAD_EN
         r_req.write <= 1'b0;
         r_req.addr  <= IRQ_STATUS_ADDR;
         r_req.wdata <= 8'h00;
`endif
      end else if (w_accept) begin
         r_req.write <= io_bus.req_write;
         r_req.addr  <= io_bus.req_addr;
         r_req.wdata <= io_bus.req_wdata;
      end
   end

`ifdef BKM_SLOT_HOST_IRQ_AUTOREAD_EN
   always_ff @(posedge clk_50mhz_in) begin
      if (!reset_x) begin
         r_auto     <= 1'b0;
         r_rsp_auto <= 1'b0;
      end else begin
         if (w_auto_start) begin
            r_auto <= 1'b1;
         end else if (w_accept) begin
            r_auto <= 1'b0;
         end
         r_rsp_auto <= (r_state == ST_DONE) && r_auto;
      end
   end

   assign io_bus.rsp_auto = r_rsp_auto;
`else
   assign io_bus.rsp_auto = 1'b0;
`endif

   // ------------------------------------------------------------------
   // FSM and phase counter
   // ------------------------------------------------------------------
   assign w_cnt_zero = (r_cnt == '0);

   always_comb begin
      w_next_state = r_state;
      case (r_state)
         ST_IDLE: begin
            if (w_auto_start || w_accept) begin
               w_next_state = ST_A_SETUP;
            end
         end
         ST_A_SETUP:  if (w_cnt_zero) w_next_state = ST_A_STROBE;
         ST_A_STROBE: if (w_cnt_zero) w_next_state = ST_A_HOLD;
         ST_A_HOLD: begin
            if (w_cnt_zero) begin
               w_next_state = r_req.write ? ST_D_SETUP : ST_TURN;
            end
         end
         ST_TURN:     if (w_cnt_zero) w_next_state = ST_D_SETUP;
         ST_D_SETUP:  if (w_cnt_zero) w_next_state = ST_D_STROBE;
         ST_D_STROBE: if (w_cnt_zero) w_next_state = ST_D_HOLD;
         ST_D_HOLD:   if (w_cnt_zero) w_next_state = ST_DONE;
         ST_DONE:     w_next_state = ST_IDLE;
         default:     w_next_state = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk_50mhz_in) begin
      if (!reset_x) begin
         r_state <= ST_IDLE;
         r_cnt   <= '0;
      end else begin
         r_state <= w_next_state;
         // Every state change reloads; no two consecutive states are equal.
         if (w_next_state != r_state) begin
            r_cnt <= phase_load(w_next_state, SETUP_CYCLES, STROBE_CYCLES,
                                HOLD_CYCLES, TURN_CYCLES);
         end else if (!w_cnt_zero) begin
            r_cnt <= r_cnt - CNT_W'(1);
         end
      end
   end

   assign o_dbg_state = r_state;

   // ------------------------------------------------------------------
   // Bus drive (registered from the current state)
   // ------------------------------------------------------------------
   assign w_in_txn  = (r_state >= ST_A_SETUP) && (r_state <= ST_D_HOLD);
   assign w_a_phase = (r_state >= ST_A_SETUP) && (r_state <= ST_A_HOLD);
   assign w_d_phase = (r_state >= ST_D_SETUP) && (r_state <= ST_D_HOLD);
   assign w_strobe  = (r_state == ST_A_STROBE) || (r_state == ST_D_STROBE);

   always_ff @(posedge clk_50mhz_in) begin
      if (!reset_x) begin
         r_slot_x    <= 1'b1;
         r_clk_rw    <= 1'b1;
         r_ax_d      <= 1'b1;
         r_r_wx      <= 1'b1;
         r_ad_out    <= 8'h00;
         r_ad_oe_x   <= 1'b1;
         r_rdata     <= 8'h00;
         r_rsp_valid <= 1'b0;
         r_rsp_rdata <= 8'h00;
      end else begin
         r_slot_x <= !w_in_txn;
         r_clk_rw <= !w_strobe;
         r_ax_d   <= !w_a_phase;
         r_r_wx   <= w_in_txn ? ~r_req.write : 1'b1;

         if (w_a_phase) begin
            r_ad_out  <= r_req.addr;
            r_ad_oe_x <= 1'b0;
         end else if (w_d_phase && r_req.write) begin
            r_ad_out  <= r_req.wdata;
            r_ad_oe_x <= 1'b0;
         end else begin
            r_ad_out  <= 8'h00;
            r_ad_oe_x <= 1'b1;
         end

         // Sample the card on the final strobe-low cycle of the data phase.
         if ((r_state == ST_D_STROBE) && w_cnt_zero && !r_req.write) begin
            r_rdata <= io_bus.ad_in;
         end

         r_rsp_valid <= (r_state == ST_DONE);
         if (r_state == ST_DONE) begin
            r_rsp_rdata <= r_req.write ? 8'h00 : r_rdata;
         end
      end
   end

   // ------------------------------------------------------------------
   // Interrupt latch: a new edge always wins over any clear source
   // ------------------------------------------------------------------
   always_ff @(posedge clk_50mhz_in) begin
      if (!reset_x) begin
         r_irq_pending <= 1'b0;
      end else if (w_irq_edge) begin
         r_irq_pending <= 1'b1;
      end else if (io_bus.irq_ack || w_auto_clr) begin
         r_irq_pending <= 1'b0;
      end
   end

   assign io_bus.slot_x_int_x = r_slot_x;
   assign io_bus.clk_rw       = r_clk_rw;
   assign io_bus.ax_d         = r_ax_d;
   assign io_bus.r_wx         = r_r_wx;
   assign io_bus.ad_out       = r_ad_out;
   assign io_bus.ad_oe_x      = r_ad_oe_x;
   assign io_bus.rsp_valid    = r_rsp_valid;
   assign io_bus.rsp_rdata    = r_rsp_rdata;
   assign io_bus.irq_pending  = r_irq_pending;

endmodule

// File: tb/tb_bkm_slot_host.sv
// ---------------------------------------------------------------------------
// tb_bkm_slot_host
// Directed bench for bkm_slot_host. Requests push their expected response
// {latency, rsp_auto, rsp_rdata} into exp_q; a monitor pops and compares on
// every rsp_valid. Bus shape, reset abort and IRQ latch behaviour are
// checked inline by the stimulus sequence.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_bkm_slot_host;

   logic       clk     = 1'b0;
   logic       reset_x = 1'b0;
   logic [3:0] dbg_state;

   bkm_slot_host_if bus_if ();

   bkm_slot_host dut (
      .clk_50mhz_in (clk),
      .reset_x      (reset_x),
      .io_bus       (bus_if.slave),
      .o_dbg_state  (dbg_state)
   );

   always #10 clk = ~clk;

   int          vec_cnt   = 0;
   int          err_cnt   = 0;
   int          cyc       = 0;
   int          acc_total = 0;
   int          rsp_total = 0;
   logic [16:0] exp_q[$];
   int          acc_q[$];
   int          acc_log[$];
   logic [7:0]  card_rdata = 8'h00;
   logic [16:0] mon_e;
   int          mon_a;

   // Card model: drives read data while the data strobe of a read is low.
   always_comb begin
      if (!bus_if.slot_x_int_x && bus_if.ax_d && bus_if.r_wx && !bus_if.clk_rw)
         bus_if.ad_in = card_rdata;
      else
         bus_if.ad_in = 8'h00;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vec_cnt++;
      if (act !== exp) begin
         err_cnt++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic [16:0] mk(input int lat, input logic auto_f, input logic [7:0] d);
      return {8'(lat), auto_f, d};
   endfunction

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   // ---------------- acceptance monitor (cycle stamps) ----------------
   always @(posedge clk) begin
      if (!reset_x) begin
         acc_q.delete();
      end else if (bus_if.req_valid && bus_if.req_ready) begin
         acc_q.push_back(cyc);
         acc_log.push_back(cyc);
         acc_total++;
      end
      cyc++;
   end

   // ---------------- response scoreboard ----------------
   always @(negedge clk) begin
      if (bus_if.rsp_valid) begin
         rsp_total++;
         chk("rsp_expected", 32'(exp_q.size() != 0), 32'd1);
         if (exp_q.size() != 0) begin
            mon_e = exp_q.pop_front();
            chk("rsp_rdata", 32'(bus_if.rsp_rdata), 32'(mon_e[7:0]));
            chk("rsp_auto", 32'(bus_if.rsp_auto), 32'(mon_e[8]));
            if (mon_e[16:9] != 8'd0) begin
               chk("rsp_has_accept", 32'(acc_q.size() != 0), 32'd1);
               if (acc_q.size() != 0) begin
                  mon_a = acc_q.pop_front();
                  chk("rsp_latency", 32'(cyc - mon_a - 1), 32'(mon_e[16:9]));
               end
            end
         end
      end
   end

   // Issue one request at a negedge and wait (bounded) for its acceptance.
   task automatic issue(input logic w, input logic [7:0] addr, input logic [7:0] wdata,
                        input logic [16:0] exp, input logic push);
      int start;
      int t;
      start = acc_total;
      t     = 0;
      bus_if.req_write = w;
      bus_if.req_addr  = addr;
      bus_if.req_wdata = wdata;
      bus_if.req_valid = 1'b1;
      if (push) exp_q.push_back(exp);
      do begin
         @(negedge clk);
         t++;
      end while (acc_total == start && t < 100);
      bus_if.req_valid = 1'b0;
      chk("accept_seen", 32'(acc_total - start), 32'd1);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int a_cnt, a_strb, d_cnt, rw_bad, oe_bad;
      int base, n0, seen_low, hi_run, gap, rsp_before;
      logic switched;

      bus_if.req_valid = 1'b0;
      bus_if.req_write = 1'b0;
      bus_if.req_addr  = 8'h00;
      bus_if.req_wdata = 8'h00;
      bus_if.irq_x     = 1'b1;
      bus_if.irq_ack   = 1'b0;

      // ---------------- reset state ----------------
      tick(3);
      reset_x = 1'b1;
      tick(1);
      chk("rst_slot_x_int_x", 32'(bus_if.slot_x_int_x), 32'd1);
      chk("rst_clk_rw",       32'(bus_if.clk_rw),       32'd1);
      chk("rst_ax_d",         32'(bus_if.ax_d),         32'd1);
      chk("rst_r_wx",         32'(bus_if.r_wx),         32'd1);
      chk("rst_ad_oe_x",      32'(bus_if.ad_oe_x),      32'd1);
      chk("rst_ad_out",       32'(bus_if.ad_out),       32'd0);
      chk("rst_rsp_valid",    32'(bus_if.rsp_valid),    32'd0);
      chk("rst_rsp_rdata",    32'(bus_if.rsp_rdata),    32'd0);
      chk("rst_rsp_auto",     32'(bus_if.rsp_auto),     32'd0);
      chk("rst_irq_pending",  32'(bus_if.irq_pending),  32'd0);
      chk("rst_req_ready",    32'(bus_if.req_ready),    32'd1);
      chk("rst_dbg_state",    32'(dbg_state),           32'd0);

      // ---------------- write 0x12 <- 0xA5 ----------------
      issue(1'b1, 8'h12, 8'hA5, mk(33, 1'b0, 8'h00), 1'b1);
      a_cnt = 0; a_strb = 0; d_cnt = 0; rw_bad = 0;
      for (int i = 0; i < 40; i++) begin
         if (!bus_if.slot_x_int_x && !bus_if.ax_d && bus_if.ad_out == 8'h12 && !bus_if.ad_oe_x) begin
            a_cnt++;
            if (!bus_if.clk_rw) a_strb++;
         end
         if (!bus_if.slot_x_int_x && bus_if.ax_d && bus_if.ad_out == 8'hA5 && !bus_if.ad_oe_x) d_cnt++;
         if (!bus_if.slot_x_int_x && bus_if.r_wx) rw_bad++;
         @(negedge clk);
      end
      chk("wr_addr_cycles",   32'(a_cnt),  32'd16);
      chk("wr_addr_strobe",   32'(a_strb), 32'd8);
      chk("wr_data_cycles",   32'(d_cnt),  32'd16);
      chk("wr_r_wx_not_low",  32'(rw_bad), 32'd0);

      // ---------------- read 0x05 -> 0x3C ----------------
      card_rdata = 8'h3C;
      issue(1'b0, 8'h05, 8'h00, mk(35, 1'b0, 8'h3C), 1'b1);
      a_cnt = 0; d_cnt = 0; rw_bad = 0; oe_bad = 0;
      for (int i = 0; i < 40; i++) begin
         if (!bus_if.slot_x_int_x && !bus_if.ax_d && bus_if.ad_out == 8'h05 && !bus_if.ad_oe_x) a_cnt++;
         if (!bus_if.slot_x_int_x && bus_if.ax_d) begin
            d_cnt++;
            if (!bus_if.ad_oe_x) oe_bad++;
         end
         if (!bus_if.slot_x_int_x && !bus_if.r_wx) rw_bad++;
         @(negedge clk);
      end
      chk("rd_addr_cycles",  32'(a_cnt),  32'd16);
      chk("rd_turn_data",    32'(d_cnt),  32'd18);
      chk("rd_oe_released",  32'(oe_bad), 32'd0);
      chk("rd_r_wx_not_hi",  32'(rw_bad), 32'd0);

      // ---------------- back-to-back write then read ----------------
      tick(2);
      card_rdata = 8'h81;
      base = acc_total;
      n0   = acc_log.size();
      exp_q.push_back(mk(33, 1'b0, 8'h00));
      exp_q.push_back(mk(35, 1'b0, 8'h81));
      bus_if.req_write = 1'b1;
      bus_if.req_addr  = 8'h33;
      bus_if.req_wdata = 8'h5A;
      bus_if.req_valid = 1'b1;
      switched = 1'b0;
      seen_low = 0; hi_run = 0; gap = -1;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (acc_total == base + 1 && !switched) begin
            bus_if.req_write = 1'b0;
            bus_if.req_addr  = 8'h44;
            switched = 1'b1;
         end
         if (acc_total >= base + 2) bus_if.req_valid = 1'b0;
         if (!bus_if.slot_x_int_x) begin
            if (seen_low != 0 && hi_run > 0 && gap < 0) gap = hi_run;
            seen_low = 1;
            hi_run   = 0;
         end else if (seen_low != 0) begin
            hi_run++;
         end
      end
      bus_if.req_valid = 1'b0;
      chk("b2b_accepts", 32'(acc_total - base), 32'd2);
      if (acc_log.size() >= n0 + 2)
         chk("b2b_accept_spacing", 32'(acc_log[n0+1] - acc_log[n0]), 32'd34);
      chk("b2b_slot_high_gap", 32'(gap), 32'd2);

      // ---------------- reset during write data strobe ----------------
      issue(1'b1, 8'h77, 8'h11, 17'd0, 1'b0);
      tick(22);
      chk("abort_in_strobe", 32'(bus_if.clk_rw), 32'd0);
      reset_x = 1'b0;
      rsp_before = rsp_total;
      tick(1);
      reset_x = 1'b1;
      chk("abort_slot_x_int_x", 32'(bus_if.slot_x_int_x), 32'd1);
      chk("abort_clk_rw",       32'(bus_if.clk_rw),       32'd1);
      chk("abort_ax_d",         32'(bus_if.ax_d),         32'd1);
      chk("abort_r_wx",         32'(bus_if.r_wx),         32'd1);
      chk("abort_ad_oe_x",      32'(bus_if.ad_oe_x),      32'd1);
      chk("abort_ad_out",       32'(bus_if.ad_out),       32'd0);
      tick(40);
      chk("abort_no_rsp",       32'(rsp_total - rsp_before), 32'd0);
      chk("abort_req_ready",    32'(bus_if.req_ready),    32'd1);

`ifndef BKM_SLOT_HOST_IRQ_AUTOREAD_EN
      // ---------------- IRQ latch ----------------
      bus_if.irq_x = 1'b0;
      tick(3);
      chk("irq_set_3cyc", 32'(bus_if.irq_pending), 32'd1);
      bus_if.irq_x = 1'b1;
      tick(5);
      chk("irq_held_no_ack", 32'(bus_if.irq_pending), 32'd1);
      bus_if.irq_x = 1'b0;
      tick(2);
      bus_if.irq_ack = 1'b1;
      tick(1);
      bus_if.irq_ack = 1'b0;
      chk("irq_set_beats_ack", 32'(bus_if.irq_pending), 32'd1);
      bus_if.irq_ack = 1'b1;
      tick(1);
      bus_if.irq_ack = 1'b0;
      chk("irq_ack_clears", 32'(bus_if.irq_pending), 32'd0);
      tick(5);
      chk("irq_level_no_reset", 32'(bus_if.irq_pending), 32'd0);
      bus_if.irq_x = 1'b1;
`else
      // ---------------- automatic status read ----------------
      card_rdata = 8'h5E;
      exp_q.push_back(mk(0, 1'b1, 8'h5E));
      bus_if.irq_x = 1'b0;
      a_cnt = 0;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (!bus_if.slot_x_int_x && !bus_if.ax_d && bus_if.ad_out == 8'h00 &&
             !bus_if.ad_oe_x && bus_if.r_wx) a_cnt++;
      end
      chk("auto_addr_cycles", 32'(a_cnt), 32'd16);
      chk("auto_pending_clr", 32'(bus_if.irq_pending), 32'd0);
      bus_if.irq_x = 1'b1;
`endif

      tick(5);
      chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end

endmodule
